pipe_skid_buffer: RTL and testbench

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_skid_buffer_if.sv | 26 ++
 rtl/ff.sv | 22 ++
 rtl/pipe_skid_buffer.sv | 111 +++++++++++
 tb/tb_pipe_skid_buffer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the two-entry pipeline skid buffer.
package pipe_pkg;

    // Width of the occupancy count (0..2 entries)
    localparam int OCC_W = 2;

    // Buffer state; the encoding equals the number of held entries
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Number of entries held in a given state
    function automatic logic [OCC_W-1:0] occ_of(input skid_state_t s);
        case (s)
            SKID_EMPTY: occ_of = 2'd0;
            SKID_BUSY:  occ_of = 2'd1;
            SKID_FULL:  occ_of = 2'd2;
            default:    occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// Upstream/downstream handshake bundle of the skid buffer.
interface pipe_skid_buffer_if #(
    parameter int WIDTH = 32
);
    import pipe_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;

    // Producer/consumer side that talks to the buffer
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // The buffer itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/ff.sv
// Enabled register with synchronous active-high reset.
module ff #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear to the reset value when reset is sampled high
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: main feeds the output, skid catches the one
// extra word accepted while downstream stalls, so in_ready is a pure
// function of the registered state.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 flush,
    pipe_skid_buffer_if.slave   bus
);

    skid_state_t      state;
    skid_state_t      state_next;
    logic [1:0]       state_q;
    logic             state_en;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             main_en;
    logic [WIDTH-1:0] skid_q;
    logic             skid_en;
    logic             in_fire;
    logic             out_fire;

    assign state = skid_state_t'(state_q);

    assign bus.in_ready  = (state != SKID_FULL);
    assign bus.out_valid = (state != SKID_EMPTY);
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_of(state);

    assign in_fire  = bus.in_valid  & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    // Next state and register enables; flush overrides any handshake
    always_comb begin
        state_next = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = bus.in_data;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        main_en    = 1'b1;
                        state_next = SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en    = 1'b1;
                        state_next = SKID_FULL;
                    end else if (out_fire) begin
                        state_next = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        main_d     = skid_q;
                        main_en    = 1'b1;
                        state_next = SKID_BUSY;
                    end
                end
                default: begin
                    state_next = SKID_EMPTY;
                end
            endcase
        end
        state_en = (state_next != state);
    end

    ff #(
        .WIDTH       (2),
        .RESET_VALUE (2'(SKID_EMPTY))
    ) u_state (
        .clk   (clk),
        .reset (reset),
        .en    (state_en),
        .d     (2'(state_next)),
        .q     (state_q)
    );

    ff #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    ff #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (bus.in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer against a queue-based model.
module tb_pipe_skid_buffer;

    logic clk;
    logic reset;
    logic flush;

    int checkCount;
    int failCount;

    // Reference model: FIFO contents (capacity 2) and the value on out_data
    logic [31:0] modelQ[$];
    logic [31:0] modelMain;

    pipe_skid_buffer_if #(.WIDTH(32)) bus ();

    pipe_skid_buffer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive all inputs for the coming cycle
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [31:0] id, input logic ordy);
        reset         = rst;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
    endtask

    // Compare all visible outputs with the model
    task automatic checkModel(input string tag);
        checkOutput({tag, "_occ"},   32'(bus.occupancy), 32'(modelQ.size()));
        checkOutput({tag, "_rdy"},   32'(bus.in_ready),  32'(modelQ.size() < 2));
        checkOutput({tag, "_vld"},   32'(bus.out_valid), 32'(modelQ.size() > 0));
        checkOutput({tag, "_data"},  bus.out_data,       modelMain);
    endtask

    // Advance one clock, step the model with the inputs seen at the edge, check
    task automatic clockCycle(input string tag);
        logic acc;
        logic pop;
        @(posedge clk);
        if (reset) begin
            modelQ.delete();
            modelMain = '0;
        end else if (flush) begin
            modelQ.delete();
        end else begin
            acc = bus.in_valid && (modelQ.size() < 2);
            pop = (modelQ.size() > 0) && bus.out_ready;
            if (pop) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(bus.in_data);
            if (modelQ.size() > 0) modelMain = modelQ[0];
        end
        #1;
        checkModel(tag);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        checkCount = 0;
        failCount  = 0;
        modelMain  = '0;

        // Reset with a valid offer that must be discarded
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        clockCycle("reset");
        checkOutput("reset_outdata0", bus.out_data, 32'h0);

        // Single word, latency one
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA5, 1'b1);
        clockCycle("single");
        checkOutput("single_a5", bus.out_data, 32'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        clockCycle("single_drain");

        // Full-rate stream 1..8
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
            clockCycle("stream");
            checkOutput("stream_seq", bus.out_data, 32'(i));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        clockCycle("stream_drain");

        // Fill, ignored offer, then drain in order
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        clockCycle("fill1");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        clockCycle("fill2");
        checkOutput("full_rdy0", 32'(bus.in_ready), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h33, 1'b0);
        clockCycle("full_hold");
        checkOutput("full_hold_11", bus.out_data, 32'h11);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        clockCycle("drain1");
        checkOutput("drain_22", bus.out_data, 32'h22);
        clockCycle("drain2");
        checkOutput("drain_rdy1", 32'(bus.in_ready), 32'h1);

        // Flush while full, with an offer that must vanish
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        clockCycle("ffill1");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        clockCycle("ffill2");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h44, 1'b0);
        clockCycle("flush");
        checkOutput("flush_vld0", 32'(bus.out_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        clockCycle("flush_idle");

        // Reset while busy
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        clockCycle("busy55");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h66, 1'b0);
        clockCycle("rst_busy");
        checkOutput("rst_busy_data0", bus.out_data, 32'h0);

        // Random traffic; in_ready must not move when out_ready toggles
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                          $urandom, $urandom_range(0, 1));
            #1;
            checkOutput("rand_rdy_a", 32'(bus.in_ready), 32'(modelQ.size() < 2));
            bus.out_ready = ~bus.out_ready;
            #1;
            checkOutput("rand_rdy_b", 32'(bus.in_ready), 32'(modelQ.size() < 2));
            bus.out_ready = ~bus.out_ready;
            clockCycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
